sbox_layer_seq: RTL and testbench



---
 rtl/sbox_layer_seq.sv | 120 ++++++++++++
 tb/tb_sbox_layer_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_layer_seq.sv
// Iterative 4-bit S-box substitution layer: LANES nibbles per clock, forward or
// inverse table selected per block, valid/ready on both sides.
module sbox_layer_seq #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LANES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned STEPS  = DATA_W / (4 * LANES);
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if ((LANES < 1) || (LANES > DATA_W / 4) || ((DATA_W % (4 * LANES)) != 0)) begin : g_bad_cfg
      $error("sbox_layer_seq: DATA_W must be a multiple of 4*LANES, LANES in 1..DATA_W/4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic                inv_q, inv_d;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  int unsigned idx;
  logic [3:0]  nib;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    work_d  = work_q;
    inv_d   = inv_q;
    idx     = 0;
    nib     = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          inv_d   = in_inv;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Nibble group for this step; lowest group first.
        for (int unsigned l = 0; l < LANES; l++) begin
          idx = 32'(step_q) * LANES + l;
          nib = work_q[4*idx +: 4];
          work_d[4*idx +: 4] = inv_q ? sbox_inv(nib) : sbox_fwd(nib);
        end
        if (step_q == STEP_W'(STEPS - 1)) begin
          step_d  = '0;
          state_d = DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Scoreboard bench for sbox_layer_seq: default, LANES=16 and LANES=1 instances.
module tb_sbox_layer_seq;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_inv;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        busy      [3];
  logic [63:0] out_data  [3];

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  localparam logic [3:0] FWD [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] INV [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                       4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
  localparam int LAT [3] = '{4, 1, 16};

  sbox_layer_seq #(.DATA_W(64), .LANES(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

  sbox_layer_seq #(.DATA_W(64), .LANES(16)) u_dut_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  sbox_layer_seq #(.DATA_W(64), .LANES(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  function automatic logic [63:0] ref_sub(input logic [63:0] d, input logic inv);
    logic [63:0] r;
    for (int i = 0; i < 16; i++)
      r[4*i +: 4] = inv ? INV[d[4*i +: 4]] : FWD[d[4*i +: 4]];
    return r;
  endfunction

  // Wait for in_ready, present one word for one accept edge, push its expectation.
  task automatic send_word(input int k, input logic [63:0] d, input logic inv,
                           input logic [63:0] expv, input bit keep_valid);
    int t = 0;
    while (in_ready[k] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (in_ready[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL send_in_ready[%0d]: got %b need 1", k, in_ready[k]);
    end
    in_data     = d;
    in_inv      = inv;
    in_valid[k] = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    if (!keep_valid) in_valid[k] = 1'b0;
    n_cmp++;
    if (busy[k] !== 1'b1 || in_ready[k] !== 1'b0) begin
      n_bad++;
      $display("FAIL accept_state[%0d]: got busy=%b in_ready=%b need busy=1 in_ready=0",
               k, busy[k], in_ready[k]);
    end
  endtask

  // Wait for out_valid, check latency and data, optionally stall, then handshake.
  task automatic collect(input int k, input int hold, input bit scramble);
    int lat = 0;
    logic [63:0] expv;
    while (out_valid[k] !== 1'b1 && lat < 100) begin
      if (scramble) begin
        in_data = {$urandom, $urandom};
        in_inv  = ~in_inv;
      end
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != LAT[k]) begin
      n_bad++;
      $display("FAIL latency[%0d]: got %0d need %0d", k, lat, LAT[k]);
    end
    expv = '0;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard[%0d]: got empty queue need one entry", k);
    end else begin
      expv = exp_q.pop_front();
    end
    n_cmp++;
    if (out_data[k] !== expv || in_ready[k] !== 1'b0) begin
      n_bad++;
      $display("FAIL out_data[%0d]: got %h in_ready=%b need %h in_ready=0",
               k, out_data[k], in_ready[k], expv);
    end
    for (int h = 0; h < hold; h++) begin
      if (scramble) begin
        in_data = {$urandom, $urandom};
        in_inv  = ~in_inv;
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid[k] !== 1'b1 || out_data[k] !== expv || in_ready[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL hold[%0d] cycle %0d: got v=%b d=%h rdy=%b need v=1 d=%h rdy=0",
                 k, h, out_valid[k], out_data[k], in_ready[k], expv);
      end
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    n_cmp++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake[%0d]: got v=%b rdy=%b busy=%b need v=0 rdy=1 busy=0",
               k, out_valid[k], in_ready[k], busy[k]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data = '0;
    in_inv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
          out_data[k] !== 64'h0) begin
        n_bad++;
        $display("FAIL reset[%0d]: got rdy=%b v=%b busy=%b d=%h need 1 0 0 0",
                 k, in_ready[k], out_valid[k], busy[k], out_data[k]);
      end
    end
  endtask

  task automatic test_forward_inverse();
    send_word(0, 64'h0, 1'b0, 64'hCCCCCCCCCCCCCCCC, 1'b0);
    collect(0, 0, 1'b0);
    send_word(0, 64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712, 1'b0);
    collect(0, 0, 1'b0);
    send_word(0, 64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    collect(0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    send_word(0, 64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712, 1'b0);
    collect(0, 5, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    send_word(0, 64'h0123456789ABCDEF, 1'b0, 64'h0, 1'b0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== 64'h0 ||
        busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_run_reset: got rdy=%b v=%b d=%h busy=%b need 1 0 0 0",
               in_ready[0], out_valid[0], out_data[0], busy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL aborted_block: got v=%b rdy=%b need v=0 rdy=1",
                 out_valid[0], in_ready[0]);
      end
    end
    send_word(0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2222222222222222, 1'b0);
    collect(0, 0, 1'b0);
  endtask

  task automatic test_ignore_inputs();
    send_word(0, 64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712, 1'b1);
    collect(0, 3, 1'b1);
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL extra_accept: got v=%b busy=%b pending=%0d need 0 0 0",
                 out_valid[0], busy[0], exp_q.size());
      end
    end
  endtask

  task automatic test_lanes();
    send_word(1, 64'hFEDCBA9876543210, 1'b0, 64'h21748FE3DA09B65C, 1'b0);
    collect(1, 0, 1'b0);
    send_word(2, 64'hFEDCBA9876543210, 1'b0, 64'h21748FE3DA09B65C, 1'b0);
    collect(2, 0, 1'b0);
  endtask

  task automatic test_random_roundtrip();
    logic [63:0] d, f;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 6; n++) begin
        d = {$urandom, $urandom};
        f = ref_sub(d, 1'b0);
        send_word(k, d, 1'b0, f, 1'b0);
        collect(k, n % 2, 1'b0);
        send_word(k, f, 1'b1, d, 1'b0);
        collect(k, 0, 1'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    for (int n = 0; n < 4; n++) begin
      d = {$urandom, $urandom};
      send_word(0, d, n[0], ref_sub(d, n[0]), 1'b0);
      collect(0, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_forward_inverse();
    test_backpressure();
    test_reset_mid_run();
    test_ignore_inputs();
    test_lanes();
    test_random_roundtrip();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
